// File: rtl/tracker_pkg.sv
// tracker_pkg: shared FSM state type, direction encodings and default timing constants for the sun tracker.
package tracker_pkg;
  typedef enum logic [2:0] {S_IDLE, S_COMPARE, S_STEP_AZ, S_STEP_EL, S_SETTLE} state_e;
  localparam logic DIR_EAST = 1'b1;
  localparam logic DIR_WEST = 1'b0;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int HYST_DEF = 64;
  localparam int STEP_PERIOD_DEF = 1000;
  localparam int SETTLE_DEF = 5000;
endpackage

// File: rtl/axis_stepper.sv
// axis_stepper: one-step slot generator with a saturating position counter for a single stepper axis.
module axis_stepper #(
  parameter int W = 10,
  parameter int MAX = 1023,
  parameter int STEP_PERIOD = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dir_in,
  output logic         step,
  output logic         dir,
  output logic [W-1:0] pos,
  output logic         done,
  output logic         at_max,
  output logic         at_min
);
  localparam int TW = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [W-1:0] MAXV = W'(MAX);
  localparam logic [W-1:0] CENTER = W'(MAX >> 1);
  localparam logic [TW-1:0] LAST = TW'(STEP_PERIOD - 1);
  logic [TW-1:0] timer;
  logic active;
  assign done = active && timer == LAST;
  assign at_max = pos == MAXV;
  assign at_min = pos == '0;
  // Position moves on the same edge the pulse rises, so pos is already updated while step is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      step <= 1'b0;
      dir <= 1'b0;
      pos <= CENTER;
      timer <= '0;
      active <= 1'b0;
    end else begin
      step <= start;
      if (start) begin
        active <= 1'b1;
        timer <= '0;
        dir <= dir_in;
        if (dir_in && !at_max) pos <= pos + W'(1);
        else if (!dir_in && !at_min) pos <= pos - W'(1);
      end else if (active) begin
        timer <= done ? '0 : timer + TW'(1);
        active <= !done;
      end
    end
  end
endmodule

// File: rtl/sun_tracker_ctrl.sv
// sun_tracker_ctrl: compares opposing lux pairs with hysteresis and sequences one azimuth and one elevation step per sweep.
module sun_tracker_ctrl
  import tracker_pkg::*;
#(
  parameter int HYST = HYST_DEF,
  parameter int STEP_PERIOD = STEP_PERIOD_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int AZ_MAX = 1023,
  parameter int EL_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] n_lux,
  input  logic [15:0] e_lux,
  input  logic [15:0] s_lux,
  input  logic [15:0] w_lux,
  output logic        az_step,
  output logic        az_dir,
  output logic        el_step,
  output logic        el_dir,
  output logic [9:0]  az_pos,
  output logic [7:0]  el_pos,
  output logic        busy,
  output logic        at_limit
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [16:0] H17 = 17'(HYST);
  localparam logic [CW-1:0] SLAST = CW'(SETTLE - 1);
  state_e state, state_n;
  logic [15:0] n_q, e_q, s_q, w_q;
  logic [CW-1:0] settle_cnt;
  logic el_go, el_dq;
  logic az_east, az_west, el_up, el_down;
  logic az_ok, el_ok, blocked;
  logic az_start, el_start, el_dir_in;
  logic az_done, el_done, az_max, az_min, el_max, el_min;
  // 17-bit sums keep lux + HYST from wrapping.
  assign az_east = {1'b0, e_q} > {1'b0, w_q} + H17;
  assign az_west = {1'b0, w_q} > {1'b0, e_q} + H17;
  assign el_up = {1'b0, n_q} > {1'b0, s_q} + H17;
  assign el_down = {1'b0, s_q} > {1'b0, n_q} + H17;
  assign az_ok = (az_east && !az_max) || (az_west && !az_min);
  assign el_ok = (el_up && !el_max) || (el_down && !el_min);
  assign blocked = (az_east && az_max) || (az_west && az_min) || (el_up && el_max) || (el_down && el_min);
  assign el_dir_in = state == S_COMPARE ? (el_up ? DIR_UP : DIR_DOWN) : el_dq;
  assign busy = state != S_IDLE;
  always_comb begin
    state_n = state;
    az_start = 1'b0;
    el_start = 1'b0;
    case (state)
      S_IDLE: state_n = (sample_valid && enable) ? S_COMPARE : S_IDLE;
      S_COMPARE: begin
        az_start = az_ok;
        el_start = !az_ok && el_ok;
        state_n = az_ok ? S_STEP_AZ : el_ok ? S_STEP_EL : S_IDLE;
      end
      S_STEP_AZ: begin
        el_start = az_done && el_go;
        state_n = !az_done ? S_STEP_AZ : el_go ? S_STEP_EL : S_SETTLE;
      end
      S_STEP_EL: state_n = el_done ? S_SETTLE : S_STEP_EL;
      S_SETTLE: state_n = settle_cnt == SLAST ? S_IDLE : S_SETTLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      n_q <= '0;
      e_q <= '0;
      s_q <= '0;
      w_q <= '0;
      settle_cnt <= '0;
      el_go <= 1'b0;
      el_dq <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      state <= state_n;
      settle_cnt <= state == S_SETTLE ? settle_cnt + CW'(1) : '0;
      if (state == S_IDLE && sample_valid && enable) begin
        n_q <= n_lux;
        e_q <= e_lux;
        s_q <= s_lux;
        w_q <= w_lux;
      end
      if (state == S_COMPARE) begin
        el_go <= el_ok;
        el_dq <= el_up ? DIR_UP : DIR_DOWN;
        at_limit <= blocked;
      end
    end
  end
  axis_stepper #(.W(10), .MAX(AZ_MAX), .STEP_PERIOD(STEP_PERIOD)) u_az (
    .clk(clk), .rst(rst), .start(az_start), .dir_in(az_east ? DIR_EAST : DIR_WEST),
    .step(az_step), .dir(az_dir), .pos(az_pos), .done(az_done), .at_max(az_max), .at_min(az_min)
  );
  axis_stepper #(.W(8), .MAX(EL_MAX), .STEP_PERIOD(STEP_PERIOD)) u_el (
    .clk(clk), .rst(rst), .start(el_start), .dir_in(el_dir_in),
    .step(el_step), .dir(el_dir), .pos(el_pos), .done(el_done), .at_max(el_max), .at_min(el_min)
  );
endmodule

// File: tb/tb_sun_tracker_ctrl.sv
// tb_sun_tracker_ctrl: directed sweeps with hand-computed step timing, positions and limit flags.
module tb_sun_tracker_ctrl;
  localparam int P = 4;
  localparam int S = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic sample_valid = 1'b0;
  logic [15:0] n_lux = '0, e_lux = '0, s_lux = '0, w_lux = '0;
  logic az_step, az_dir, el_step, el_dir, busy, at_limit;
  logic [9:0] az_pos;
  logic [7:0] el_pos;
  int total = 0;
  int bad = 0;
  int az_at, el_at, az_cnt, el_cnt, az_d, el_d, idle_at;
  sun_tracker_ctrl #(.HYST(64), .STEP_PERIOD(P), .SETTLE(S), .AZ_MAX(1023), .EL_MAX(255)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .n_lux(n_lux), .e_lux(e_lux), .s_lux(s_lux), .w_lux(w_lux),
    .az_step(az_step), .az_dir(az_dir), .el_step(el_step), .el_dir(el_dir),
    .az_pos(az_pos), .el_pos(el_pos), .busy(busy), .at_limit(at_limit)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Pulses sample_valid at index 0; indices count negedges after that (1 = cycle t+1).
  task automatic sweep(input int e, input int w, input int n, input int s, input int inj);
    e_lux = 16'(e); w_lux = 16'(w); n_lux = 16'(n); s_lux = 16'(s);
    sample_valid = 1'b1;
    az_at = -1; el_at = -1; az_cnt = 0; el_cnt = 0; az_d = -1; el_d = -1; idle_at = -1;
    for (int i = 1; i <= 200 && idle_at < 0; i++) begin
      @(negedge clk);
      sample_valid = (i == inj);
      if (az_step) begin az_cnt++; if (az_at < 0) az_at = i; az_d = int'(az_dir); end
      if (el_step) begin el_cnt++; if (el_at < 0) el_at = i; el_d = int'(el_dir); end
      if (!busy && i != inj) idle_at = i;
    end
    sample_valid = 1'b0;
    if (idle_at < 0) chk("sweep_timeout", idle_at, 0);
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_az_pos", az_pos, 511);
    chk("rst_el_pos", el_pos, 127);
    chk("rst_az_step", az_step, 0);
    chk("rst_el_step", el_step, 0);
    chk("rst_az_dir", az_dir, 0);
    chk("rst_el_dir", el_dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_at_limit", at_limit, 0);
    rst = 1'b0;
    @(negedge clk);
    sweep(1000, 500, 800, 800, -1);
    chk("east_az_at", az_at, 2);
    chk("east_az_cnt", az_cnt, 1);
    chk("east_az_dir", az_d, 1);
    chk("east_az_pos", az_pos, 512);
    chk("east_el_cnt", el_cnt, 0);
    chk("east_idle_at", idle_at, P + S + 2);
    sweep(564, 500, 800, 800, -1);
    chk("hyst_eq_az_cnt", az_cnt, 0);
    chk("hyst_eq_idle_at", idle_at, 2);
    chk("hyst_eq_az_pos", az_pos, 512);
    sweep(565, 500, 800, 800, -1);
    chk("hyst_p1_az_cnt", az_cnt, 1);
    chk("hyst_p1_az_pos", az_pos, 513);
    sweep(900, 100, 100, 900, -1);
    chk("both_az_at", az_at, 2);
    chk("both_el_at", el_at, 2 + P);
    chk("both_el_dir", el_d, 0);
    chk("both_el_cnt", el_cnt, 1);
    chk("both_el_pos", el_pos, 126);
    chk("both_az_pos", az_pos, 514);
    chk("both_idle_at", idle_at, 2 * P + S + 2);
    sweep(1000, 500, 800, 800, P + 4);
    repeat (20) @(negedge clk);
    chk("settle_drop_az_pos", az_pos, 515);
    chk("settle_drop_busy", busy, 0);
    enable = 1'b0;
    sweep(1000, 500, 800, 800, -1);
    chk("disabled_az_cnt", az_cnt, 0);
    chk("disabled_idle_at", idle_at, 1);
    chk("disabled_az_pos", az_pos, 515);
    enable = 1'b1;
    for (int k = 0; k < 600 && az_pos != 10'd1023; k++) sweep(2000, 0, 800, 800, -1);
    chk("limit_reach_az_pos", az_pos, 1023);
    chk("limit_reach_flag", at_limit, 0);
    sweep(2000, 0, 800, 800, -1);
    chk("limit_az_cnt", az_cnt, 0);
    chk("limit_flag", at_limit, 1);
    chk("limit_az_pos", az_pos, 1023);
    chk("limit_idle_at", idle_at, 2);
    sweep(800, 800, 800, 800, -1);
    chk("limit_clear_flag", at_limit, 0);
    e_lux = 16'd500; w_lux = 16'd1000; n_lux = 16'd800; s_lux = 16'd800;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    chk("west_step_hi", az_step, 1);
    chk("west_dir", az_dir, 0);
    chk("west_pos", az_pos, 1022);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_az_step", az_step, 0);
    chk("midrst_az_pos", az_pos, 511);
    chk("midrst_el_pos", el_pos, 127);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
